// File: rtl/edge_result_collector.sv
// Captures the edge-detector pixel stream into a word-packed frame buffer with an Avalon-MM CSR/readback port.
// Optional frame-done interrupt output irq_o is built when COLLECTOR_IRQ_EN is defined.
`timescale 1ns/1ps
module edge_result_collector #(
  parameter int unsigned IMG_X_SIZE = 100,
  parameter int unsigned IMG_Y_SIZE = 100,
  parameter int unsigned KX_SIZE    = 3,
  parameter int unsigned KY_SIZE    = 3,
  parameter int unsigned OUT_PIXELS = (IMG_X_SIZE - KX_SIZE + 1) * (IMG_Y_SIZE - KY_SIZE + 1),
  parameter int unsigned OUT_WORDS  = (OUT_PIXELS + 3) / 4,
  parameter int unsigned ADDR_W     = $clog2(OUT_WORDS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [7:0]        pixel_i,
  input  logic [ADDR_W-1:0] avs_address_i,
  input  logic              avs_read_i,
  input  logic              avs_write_i,
  input  logic [31:0]       avs_writedata_i,
  output logic [31:0]       avs_readdata_o,
  output logic              avs_readdatavalid_o,
  output logic              avs_waitrequest_o
`ifdef COLLECTOR_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int unsigned WIDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [31:0]       mem_q [OUT_WORDS];
  logic [31:0]       buf_rdata_q;
  logic [31:0]       csr_rdata_q, csr_rdata_d;
  logic              buf_sel_q;
  logic              rvalid_q;

  logic              csr_wr, start, ack, cap, rd_acc, in_buf, csr_addr;
  logic [WIDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]       csr_val;
  logic              unused_wdata;

  assign csr_addr = (avs_address_i == '0);
  assign csr_wr   = avs_write_i && csr_addr;
  assign start    = csr_wr && avs_writedata_i[0];
  assign ack      = csr_wr && avs_writedata_i[1] && (state_q == ST_DONE);
  assign cap      = (state_q == ST_CAPTURE) && valid_i;
  assign rd_acc   = avs_read_i && !avs_write_i;
  assign in_buf   = !csr_addr && (avs_address_i <= ADDR_W'(OUT_WORDS));
  assign wr_idx   = count_q[2 +: WIDX_W];
  assign rd_idx   = WIDX_W'(avs_address_i - ADDR_W'(1));
  assign csr_val  = {count_q, 13'b0, ovf_q, done_q, (state_q == ST_CAPTURE)};
  assign unused_wdata = ^avs_writedata_i[31:2];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (cap) begin
      count_d = count_q + 1'b1;
      if (count_q == CNT_W'(OUT_PIXELS - 1)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
    if ((state_q == ST_DONE) && valid_i) begin
      ovf_d = 1'b1;
    end
    // START overrides both a same-cycle capture and a same-cycle ACK
    if (start) begin
      state_d = ST_CAPTURE;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (ack) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    csr_rdata_d = '0;
    if (rd_acc && csr_addr) begin
      csr_rdata_d = csr_val;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      buf_sel_q   <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      rvalid_q    <= rd_acc;
      buf_sel_q   <= rd_acc && in_buf;
      csr_rdata_q <= csr_rdata_d;
    end
  end

  // Synchronous read-before-write: a same-cycle capture to the word returns its old contents
  always_ff @(posedge clk_i) begin
    if (cap) begin
      mem_q[wr_idx][{count_q[1:0], 3'b000} +: 8] <= pixel_i;
    end
    if (rd_acc && in_buf) begin
      buf_rdata_q <= mem_q[rd_idx];
    end
  end

  assign avs_readdata_o      = !rvalid_q ? '0 : (buf_sel_q ? buf_rdata_q : csr_rdata_q);
  assign avs_readdatavalid_o = rvalid_q;
  assign avs_waitrequest_o   = 1'b0;

`ifdef COLLECTOR_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (state_q == ST_DONE) begin
      irq_d = 1'b1;
    end
    if (start || ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule
